// File: rtl/counter_tb_pkg.sv
// Shared types and the reference counting rule for the flex-counter checker.
// The same next_count function is reused by the software-side scoreboard.
package counter_tb_pkg;

    localparam int DEF_NUM_BITS = 4;
    localparam int DEF_TIME_W   = 16;
    localparam int DEF_ERR_W    = 8;
    localparam int CNT_MAX_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ENABLE,
        ST_HOLD,
        ST_DONE
    } state_t;

    // Wide operands so any counter width up to CNT_MAX_W can share one function.
    function automatic logic [CNT_MAX_W-1:0] next_count(
        input logic [CNT_MAX_W-1:0] count,
        input logic [CNT_MAX_W-1:0] rollover,
        input logic                 enable,
        input logic                 clear
    );
        logic [CNT_MAX_W-1:0] nxt;
        if (clear)
            nxt = '0;
        else if (enable)
            nxt = (count == rollover) ? CNT_MAX_W'(1) : count + CNT_MAX_W'(1);
        else
            nxt = count;
        return nxt;
    endfunction

endpackage

// File: rtl/counter_stim_checker_ref_model.sv
// Cycle-accurate reference of the flex counter, stepped with the same
// clear/enable/rollover the checker drives to the real counter.
module counter_ref_model
    import counter_tb_pkg::*;
#(
    parameter int NUM_BITS = DEF_NUM_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clear,
    input  logic                i_enable,
    input  logic [NUM_BITS-1:0] i_rollover,
    output logic [NUM_BITS-1:0] o_exp_count,
    output logic                o_exp_flag
);

    logic [NUM_BITS-1:0] r_exp_count;
    logic                r_exp_flag;
    logic [NUM_BITS-1:0] w_next_count;

    assign w_next_count = NUM_BITS'(next_count(CNT_MAX_W'(r_exp_count),
                                               CNT_MAX_W'(i_rollover),
                                               i_enable, i_clear));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_count <= '0;
            r_exp_flag  <= 1'b0;
        end else begin
            r_exp_count <= w_next_count;
            r_exp_flag  <= (w_next_count == i_rollover) && !i_clear;
        end
    end

    assign o_exp_count = r_exp_count;
    assign o_exp_flag  = r_exp_flag;

endmodule

// File: rtl/counter_stim_checker.sv
// Tester-side companion for the flex counter: runs one command at a time,
// drives the counter, and compares it against the lockstep reference model.
module counter_stim_checker
    import counter_tb_pkg::*;
#(
    parameter int NUM_BITS = DEF_NUM_BITS,
    parameter int TIME_W   = DEF_TIME_W,
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] cmd_rollover_val,
    input  logic [TIME_W-1:0]   cmd_enable_time,
    input  logic                cmd_clear_first,
    output logic                clear,
    output logic                count_enable,
    output logic [NUM_BITS-1:0] rollover_val,
    output logic                check,
    input  logic [NUM_BITS-1:0] count_out,
    input  logic                rollover_flag,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic                cmd_err,
    output logic [ERR_W-1:0]    err_count,
    output logic [NUM_BITS-1:0] first_err_exp,
    output logic [NUM_BITS-1:0] first_err_got
);

    state_t              r_state;
    state_t              w_next_state;
    logic [TIME_W-1:0]   r_timer;
    logic [NUM_BITS-1:0] r_rollover_val;
    logic [ERR_W-1:0]    r_err_count;
    logic                r_pass;
    logic                r_cmd_err;
    logic [NUM_BITS-1:0] r_first_err_exp;
    logic [NUM_BITS-1:0] r_first_err_got;
    logic [NUM_BITS-1:0] w_exp_count;
    logic                w_exp_flag;
    logic                w_start;
    logic                w_mismatch;

    assign w_start = (r_state == ST_IDLE) && start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (cmd_rollover_val == '0)
                        w_next_state = ST_DONE;
                    else if (cmd_clear_first)
                        w_next_state = ST_CLEAR;
                    else if (cmd_enable_time == '0)
                        w_next_state = ST_HOLD;
                    else
                        w_next_state = ST_ENABLE;
                end
            end
            ST_CLEAR:  w_next_state = (r_timer == '0) ? ST_HOLD : ST_ENABLE;
            ST_ENABLE: w_next_state = (r_timer == TIME_W'(1)) ? ST_HOLD : ST_ENABLE;
            ST_HOLD:   w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        clear        = 1'b0;
        count_enable = 1'b0;
        check        = 1'b0;
        done         = 1'b0;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_CLEAR:  clear = 1'b1;
            ST_ENABLE: begin
                count_enable = 1'b1;
                check        = 1'b1;
            end
            ST_HOLD:   check = 1'b1;
            ST_DONE:   done  = 1'b1;
            default:   ;
        endcase
    end

    counter_ref_model #(
        .NUM_BITS (NUM_BITS)
    ) u_ref (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (clear),
        .i_enable    (count_enable),
        .i_rollover  (r_rollover_val),
        .o_exp_count (w_exp_count),
        .o_exp_flag  (w_exp_flag)
    );

    assign w_mismatch = check && ((count_out != w_exp_count) || (rollover_flag != w_exp_flag));

    // The timer is untouched in CLEAR so it still holds enable_time there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer         <= '0;
            r_rollover_val  <= '0;
            r_err_count     <= '0;
            r_pass          <= 1'b0;
            r_cmd_err       <= 1'b0;
            r_first_err_exp <= '0;
            r_first_err_got <= '0;
        end else if (w_start) begin
            r_timer         <= cmd_enable_time;
            r_rollover_val  <= cmd_rollover_val;
            r_err_count     <= '0;
            r_pass          <= 1'b0;
            r_cmd_err       <= (cmd_rollover_val == '0);
            r_first_err_exp <= '0;
            r_first_err_got <= '0;
        end else begin
            if (r_state == ST_ENABLE)
                r_timer <= r_timer - TIME_W'(1);
            if (w_mismatch) begin
                if (r_err_count != '1)
                    r_err_count <= r_err_count + ERR_W'(1);
                if (r_err_count == '0) begin
                    r_first_err_exp <= w_exp_count;
                    r_first_err_got <= count_out;
                end
            end
            // HOLD is the last checked cycle, so its own compare joins the verdict.
            if (r_state == ST_HOLD)
                r_pass <= !w_mismatch && (r_err_count == '0) && !r_cmd_err;
        end
    end

    assign rollover_val  = r_rollover_val;
    assign err_count     = r_err_count;
    assign pass          = r_pass;
    assign cmd_err       = r_cmd_err;
    assign first_err_exp = r_first_err_exp;
    assign first_err_got = r_first_err_got;

endmodule

// File: tb/tb_counter_stim_checker.sv
// Bench: behavioural flex counter on the far side of the checker, with a
// scoreboard of expected per-check counter values and per-run verdicts.
module tb_counter_stim_checker;

    localparam int NB = 4;
    localparam int TW = 16;
    localparam int EW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [NB-1:0] cmd_rollover_val = '0;
    logic [TW-1:0] cmd_enable_time = '0;
    logic          cmd_clear_first = 1'b0;
    logic          clear, count_enable, check, busy, done, pass, cmd_err;
    logic [NB-1:0] rollover_val, count_out, first_err_exp, first_err_got;
    logic          rollover_flag;
    logic [EW-1:0] err_count;

    always #5 clk = ~clk;

    counter_stim_checker #(.NUM_BITS(NB), .TIME_W(TW), .ERR_W(EW)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cmd_rollover_val (cmd_rollover_val),
        .cmd_enable_time  (cmd_enable_time),
        .cmd_clear_first  (cmd_clear_first),
        .clear            (clear),
        .count_enable     (count_enable),
        .rollover_val     (rollover_val),
        .check            (check),
        .count_out        (count_out),
        .rollover_flag    (rollover_flag),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .cmd_err          (cmd_err),
        .err_count        (err_count),
        .first_err_exp    (first_err_exp),
        .first_err_got    (first_err_got)
    );

    // Stand-in flex counter; fault_en forces an observed 4 to read as 3.
    logic [NB-1:0] tc_cnt, tc_next;
    logic          tc_flag;
    logic          fault_en = 1'b0;

    always_comb begin
        tc_next = tc_cnt;
        if (clear)
            tc_next = '0;
        else if (count_enable)
            tc_next = (tc_cnt == rollover_val) ? 4'd1 : tc_cnt + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc_cnt  <= '0;
            tc_flag <= 1'b0;
        end else begin
            tc_cnt  <= tc_next;
            tc_flag <= (tc_next == rollover_val) && !clear;
        end
    end

    assign count_out     = (fault_en && tc_cnt == 4'd4) ? 4'd3 : tc_cnt;
    assign rollover_flag = tc_flag;

    typedef struct {
        logic [NB-1:0] cnt;
        logic          flag;
    } seq_t;

    typedef struct {
        logic          pass;
        logic          cmd_err;
        logic [EW-1:0] err;
        logic [NB-1:0] fexp;
        logic [NB-1:0] fgot;
        int            en;
    } res_t;

    seq_t seq_q[$];
    res_t res_q[$];
    seq_t mon_s;
    res_t mon_r;
    int   n_cmp = 0;
    int   n_err = 0;
    int   en_seen = 0;
    int   done_cnt = 0;
    logic [NB-1:0] m_cnt = '0;
    logic [NB-1:0] m_roll = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", tag, got, exp);
        end
    endtask

    // Expected counter value/flag seen in every checked cycle, plus the verdict.
    task automatic push_run(input logic [NB-1:0] roll, input int en, input bit clr, input bit flt);
        logic [NB-1:0] c;
        logic          f;
        int            errs;
        res_t          r;
        seq_t          s;
        errs = 0;
        r.fexp = '0;
        r.fgot = '0;
        if (roll != '0) begin
            c = clr ? 4'd0 : m_cnt;
            f = clr ? 1'b0 : (m_cnt == m_roll);
            for (int k = 0; k <= en; k++) begin
                s.cnt  = c;
                s.flag = f;
                seq_q.push_back(s);
                if (flt && c == 4'd4) begin
                    if (errs == 0) begin
                        r.fexp = 4'd4;
                        r.fgot = 4'd3;
                    end
                    errs++;
                end
                if (k < en) begin
                    c = (c == roll) ? 4'd1 : c + 4'd1;
                    f = (c == roll);
                end
            end
            m_cnt = c;
        end
        m_roll    = roll;
        r.cmd_err = (roll == '0);
        r.pass    = (errs == 0) && (roll != '0);
        r.err     = errs[EW-1:0];
        r.en      = (roll == '0) ? 0 : en;
        res_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (count_enable)
                en_seen++;
            if (check) begin
                check_val("seq_avail", seq_q.size() > 0, 1);
                if (seq_q.size() > 0) begin
                    mon_s = seq_q.pop_front();
                    check_val("count", tc_cnt, mon_s.cnt);
                    check_val("flag", tc_flag, mon_s.flag);
                end
            end
            if (done) begin
                done_cnt++;
                check_val("res_avail", res_q.size() > 0, 1);
                if (res_q.size() > 0) begin
                    mon_r = res_q.pop_front();
                    check_val("pass", pass, mon_r.pass);
                    check_val("cmd_err", cmd_err, mon_r.cmd_err);
                    check_val("err_count", err_count, mon_r.err);
                    check_val("first_err_exp", first_err_exp, mon_r.fexp);
                    check_val("first_err_got", first_err_got, mon_r.fgot);
                    check_val("enable_cycles", en_seen, mon_r.en);
                    check_val("checks_left", seq_q.size(), 0);
                end
                en_seen = 0;
            end
        end
    end

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_clear"}, clear, 0);
        check_val({tag, "_enable"}, count_enable, 0);
        check_val({tag, "_check"}, check, 0);
        check_val({tag, "_pass"}, pass, 0);
        check_val({tag, "_cmd_err"}, cmd_err, 0);
        check_val({tag, "_err_count"}, err_count, 0);
        check_val({tag, "_rollover_val"}, rollover_val, 0);
        check_val({tag, "_first_exp"}, first_err_exp, 0);
        check_val({tag, "_first_got"}, first_err_got, 0);
    endtask

    task automatic run_cmd(input logic [NB-1:0] roll, input int en, input bit clr,
                           input bit flt, input bit inject);
        bit   seen;
        logic exp_pass;
        int   d0;
        seen     = 1'b0;
        exp_pass = 1'b0;
        d0       = done_cnt;
        push_run(roll, en, clr, flt);
        exp_pass = res_q[res_q.size()-1].pass;
        fault_en = flt;
        @(negedge clk);
        start            = 1'b1;
        cmd_rollover_val = roll;
        cmd_enable_time  = en[TW-1:0];
        cmd_clear_first  = clr;
        @(negedge clk);
        start            = 1'b0;
        cmd_rollover_val = '0;
        cmd_enable_time  = 16'd1;
        cmd_clear_first  = 1'b0;
        check_val("busy_after_start", busy, 1);
        check_val("rollover_latched", rollover_val, roll);
        for (int i = 0; i < en + 40 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start = inject && (i == 2);
                @(negedge clk);
            end
        end
        start = 1'b0;
        check_val("done_seen", seen, 1);
        @(negedge clk);
        check_val("done_once", done_cnt - d0, 1);
        check_val("done_pulse_end", done, 0);
        check_val("busy_end", busy, 0);
        check_val("pass_held", pass, exp_pass);
        fault_en = 1'b0;
    endtask

    initial begin
        int d0;
        @(negedge clk);
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_cmd(4'd5, 7, 1'b1, 1'b0, 1'b0);
        run_cmd(4'd5, 3, 1'b0, 1'b0, 1'b0);
        run_cmd(4'd1, 4, 1'b1, 1'b0, 1'b0);
        run_cmd(4'd15, 17, 1'b1, 1'b0, 1'b0);
        run_cmd(4'd5, 7, 1'b1, 1'b1, 1'b0);
        run_cmd(4'd0, 5, 1'b0, 1'b0, 1'b0);
        run_cmd(4'd7, 0, 1'b1, 1'b0, 1'b0);

        // Abort a run while the counter is enabled.
        push_run(4'd9, 10, 1'b1, 1'b0);
        @(negedge clk);
        start            = 1'b1;
        cmd_rollover_val = 4'd9;
        cmd_enable_time  = 16'd10;
        cmd_clear_first  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_val("enable_before_rst", count_enable, 1);
        rst = 1'b1;
        @(negedge clk);
        check_idle("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        seq_q.delete();
        res_q.delete();
        en_seen = 0;
        m_cnt   = '0;
        m_roll  = '0;
        d0      = done_cnt;
        repeat (20) @(negedge clk);
        check_val("no_done_after_rst", done_cnt, d0);

        run_cmd(4'd3, 6, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_stim_checker.md
Name: counter_stim_checker

Overview:
- Synthesizable tester-side companion for the flex counter; occupies the tester end of the counter interface.
- Accepts one command at a time: rollover value, enable duration and optional clear.
- Drives clear, count_enable, rollover_val and check to the counter, and runs an internal reference model in lockstep.
- Compares count_out and rollover_flag every checked cycle, then reports pass/fail and mismatch details.

Parameters:
NUM_BITS, 4, counter width; must match the DUT.
TIME_W, 16, width of the enable-time field.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
start  in  1  command strobe; sampled only in IDLE.
cmd_rollover_val  in  NUM_BITS  rollover value for the run.
cmd_enable_time  in  TIME_W  number of cycles count_enable is held high.
cmd_clear_first  in  1  when 1, issue a one-cycle clear before enabling.
clear  out  1  to DUT.
count_enable  out  1  to DUT.
rollover_val  out  NUM_BITS  to DUT; held stable for the whole run.
check  out  1  high in cycles where DUT outputs are compared.
count_out  in  NUM_BITS  from DUT.
rollover_flag  in  1  from DUT.
busy  out  1  run in progress.
done  out  1  one-cycle pulse at end of run.
pass  out  1  valid from done until next start; 1 when zero mismatches and command legal.
cmd_err  out  1  run rejected because cmd_rollover_val == 0.
err_count  out  ERR_W  mismatches in the current run; saturates at all-ones.
first_err_exp  out  NUM_BITS  expected count at first mismatch.
first_err_got  out  NUM_BITS  DUT count at first mismatch.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; exp_count and exp_flag 0; time counter 0.
- Reset mid-run aborts immediately and produces no done pulse.
- States: IDLE, CLEAR, ENABLE, HOLD, DONE.
- IDLE, on start=1:
  - Latch command; clear err_count, pass, cmd_err and first_err_*.
  - If cmd_rollover_val==0: set cmd_err=1, go to DONE.
  - Else if cmd_clear_first: go to CLEAR.
  - Else if cmd_enable_time==0: go to HOLD.
  - Else go to ENABLE.
- CLEAR: clear=1 for exactly one cycle. Model sets exp_count=0, exp_flag=0. Next state is ENABLE, or HOLD if enable_time==0.
- ENABLE: count_enable=1 and check=1.
  - Time counter loads enable_time and decrements each cycle.
  - After enable_time cycles, go to HOLD.
- HOLD: one cycle, count_enable=0, check=1; confirms the counter holds its value. Then go to DONE.
- DONE: one cycle. done=1, busy=0 afterwards. pass=(err_count==0)&&!cmd_err. Return to IDLE.
- busy=1 in CLEAR, ENABLE, HOLD and DONE.
- start outside IDLE is ignored.
- Control outputs are decoded from the registered state. rollover_val is registered at command latch.
- Reference model updates on the same edge as the DUT, with identical inputs:
  - clear has priority: exp_count=0.
  - Else if count_enable: exp_count = (exp_count==rollover_val) ? 1 : exp_count+1.
  - exp_flag = (next exp_count == rollover_val) && no clear.
- Wrap boundaries:
  - rollover_val=1 gives 0,1,1,1…
  - rollover_val=2^NUM_BITS−1 wraps from max to 1. No modular overflow is ever used.
- Without cmd_clear_first, the model starts from its current exp_count. Used for continuation runs.
- Compare: in any cycle with check=1, mismatch = (count_out!=exp_count) || (rollover_flag!=exp_flag).
  - On mismatch, err_count increments (saturating).
  - On the first mismatch of the run, capture first_err_exp/first_err_got.

Decomposition:
- Package counter_tb_pkg holds:
  - state enum type.
  - Default NUM_BITS/TIME_W/ERR_W constants.
  - A function next_count(count, rollover, enable, clear) shared with the UVM scoreboard.
- One sub-module, counter_ref_model, holds exp_count/exp_flag registers and the next_count logic. The FSM, timer and compare logic stay in the top module.

Test Plan:
- Clear then count: rollover 5, enable 7, clear_first=1.
  - Expected count sequence: 1,2,3,4,5,1,2.
  - Flag high on the cycle count=5.
  - Correct DUT → pass=1, err_count=0, done pulses once.
- Continuation: after the run above, rollover 5, enable 3, clear_first=0.
  - Expected sequence: 3,4,5. HOLD shows 5.
  - pass=1.
- Edge values:
  - rollover 1, enable 4 → 1,1,1,1, flag constantly 1.
  - rollover 15, enable 17 → wraps 15→1.
  - Both runs pass.
- Fault injection: DUT forced to count_out=3 when expecting 4.
  - err_count≥1, first_err_exp=4, first_err_got=3, pass=0.
- Illegal and degenerate commands:
  - rollover 0 → cmd_err=1, pass=0, no enable cycles.
  - enable_time 0 with clear → clear then HOLD checks 0.
- Reset and ignored start:
  - rst during ENABLE → outputs 0 next sample, no done pulse.
  - start asserted while busy is ignored; the current run completes unchanged.
